// File: rtl/sweep_pkg.sv
// Shared types and defaults for the exhaustive sweep sequencer and its MISR.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } sweep_state_e;

    localparam int          DEFAULT_SIG_W = 16;
    localparam logic [15:0] DEFAULT_POLY  = 16'h1021;

    // Width of a down-counter that must hold values 0..settle-1 (never zero bits wide).
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: a Galois LFSR that XORs a zero-extended
// response word into the shifted state on every enabled cycle.
module misr_reg
    import sweep_pkg::*;
#(
    parameter int               SIG_W  = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY),
    parameter int               N_IN_W = 1
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [N_IN_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] din_ext;
    logic [SIG_W-1:0] sig_nxt;

    assign din_ext = SIG_W'(din);
    assign sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;

    // Signature register: cleared at the start of a sweep, folds one response per record.
    always_ff @(posedge CK or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/exhaustive_sweep_sequencer.sv
// Walks every input vector 0..2**N_IN-1 into a DUT, samples the response after
// a settle delay, emits one (vector, response) record per vector on a
// valid/ready stream and folds the responses into a MISR signature.
module exhaustive_sweep_sequencer
    import sweep_pkg::sweep_state_e;
    import sweep_pkg::DEFAULT_SIG_W;
    import sweep_pkg::DEFAULT_POLY;
    import sweep_pkg::cnt_width;
#(
    parameter int               N_IN   = 5,
    parameter int               N_OUT  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [N_OUT-1:0] rec_resp,
    output logic [SIG_W-1:0] sig_o,
    output logic             busy_o,
    output logic             done_o
);

    // The SETTLE state literal is always written scoped because the
    // parameter of the same name would otherwise shadow it.
    localparam int              CNT_W       = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = '1;

    sweep_state_e     state;
    sweep_state_e     state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic             settle_done;
    logic             last_vec;
    logic             sig_clr;
    logic             sig_en;

    assign settle_done = (settle_cnt == '0);
    assign last_vec    = (vec_o == LAST_VEC);

    // State register.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state <= sweep_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived controls (busy, MISR clear/enable).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        busy_o    = 1'b0;
        sig_clr   = 1'b0;
        sig_en    = 1'b0;
        unique case (state)
            sweep_pkg::IDLE: begin
                // Abort takes priority over a simultaneous start.
                if (start_i && !abort_i) begin
                    state_nxt = sweep_pkg::SETTLE;
                    sig_clr   = 1'b1;
                end
            end
            sweep_pkg::SETTLE: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_nxt = sweep_pkg::IDLE;
                end else if (settle_done) begin
                    state_nxt = sweep_pkg::HOLD;
                    sig_en    = 1'b1;
                end
            end
            sweep_pkg::HOLD: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_nxt = sweep_pkg::IDLE;
                end else if (rec_ready) begin
                    state_nxt = last_vec ? sweep_pkg::IDLE : sweep_pkg::SETTLE;
                end
            end
            default: begin
                state_nxt = sweep_pkg::IDLE;
            end
        endcase
    end

    // Vector counter, settle counter, record register and completion pulse.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            vec_o      <= '0;
            settle_cnt <= '0;
            rec_valid  <= 1'b0;
            rec_vec    <= '0;
            rec_resp   <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                sweep_pkg::IDLE: begin
                    if (start_i && !abort_i) begin
                        vec_o      <= '0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                sweep_pkg::SETTLE: begin
                    if (abort_i) begin
                        rec_valid <= 1'b0;
                    end else if (settle_done) begin
                        rec_vec   <= vec_o;
                        rec_resp  <= resp_i;
                        rec_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                sweep_pkg::HOLD: begin
                    if (abort_i) begin
                        rec_valid <= 1'b0;
                    end else if (rec_ready) begin
                        rec_valid <= 1'b0;
                        // The sweep stops at all-ones instead of wrapping back to 0.
                        if (last_vec) begin
                            done_o <= 1'b1;
                        end else begin
                            vec_o      <= vec_o + N_IN'(1);
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    misr_reg #(
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .N_IN_W (N_OUT)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (sig_clr),
        .en    (sig_en),
        .din   (resp_i),
        .sig   (sig_o)
    );

endmodule

// File: tb/tb_exhaustive_sweep_sequencer.sv
// Directed bench for exhaustive_sweep_sequencer (N_IN=5, SETTLE=1, SIG_W=16).
module tb_exhaustive_sweep_sequencer;

    localparam int N_IN   = 5;
    localparam int N_OUT  = 1;
    localparam int SETTLE = 1;
    localparam int SIG_W  = 16;

    logic             CK;
    logic             reset;
    logic             start_i;
    logic             abort_i;
    logic [N_IN-1:0]  vec_o;
    logic [N_OUT-1:0] resp_i;
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_resp;
    logic [SIG_W-1:0] sig_o;
    logic             busy_o;
    logic             done_o;

    int resp_mode;
    int pass_cnt;
    int check_cnt;
    int cyc;
    int done_cnt;
    int rec_vec_q[$];
    int rec_resp_q[$];

    exhaustive_sweep_sequencer #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (SETTLE),
        .SIG_W  (SIG_W),
        .POLY   (16'h1021)
    ) dut (
        .CK        (CK),
        .reset     (reset),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .vec_o     (vec_o),
        .resp_i    (resp_i),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_vec   (rec_vec),
        .rec_resp  (rec_resp),
        .sig_o     (sig_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    // Modelled DUT under test: 0 = tied low, 1 = high only at all-ones, 2 = LSB of the vector.
    always_comb begin
        resp_i = '0;
        if (resp_mode == 1) begin
            resp_i = N_OUT'(vec_o == '1);
        end else if (resp_mode == 2) begin
            resp_i = N_OUT'(vec_o[0]);
        end
    end

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Logger: a record is taken on each edge where valid and ready are both high.
    always @(negedge CK) begin
        if (!reset && rec_valid && rec_ready) begin
            rec_vec_q.push_back(int'(rec_vec));
            rec_resp_q.push_back(int'(rec_resp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({vec_o, rec_valid, rec_vec, rec_resp, sig_o, busy_o, done_o});
    endfunction

    function automatic int order_errors();
        int e = 0;
        foreach (rec_vec_q[i]) begin
            if (rec_vec_q[i] != i) e++;
        end
        return e;
    endfunction

    function automatic int resp_sum();
        int s = 0;
        foreach (rec_resp_q[i]) s += rec_resp_q[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
        cyc++;
        if (done_o) done_cnt++;
    endtask

    task automatic start_sweep();
        rec_vec_q.delete();
        rec_resp_q.delete();
        start_i = 1'b1;
        tick();
        start_i  = 1'b0;
        cyc      = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_o) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_rec(input string tag, input int v);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (rec_valid && int'(rec_vec) == v) seen = 1'b1;
            else tick();
        end
        check({tag, "_rec_reached"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_vec(input string tag, input int v);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (int'(vec_o) == v) seen = 1'b1;
            else tick();
        end
        check({tag, "_vec_reached"}, 32'(seen), 32'd1);
    endtask

    task automatic full_sweep(input string tag, input int exp_cycles, input logic [15:0] exp_sig);
        wait_done(tag, 200);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_rec_count"}, 32'(rec_vec_q.size()), 32'd32);
        check({tag, "_rec_order"}, 32'(order_errors()), 32'd0);
        check({tag, "_sig"}, 32'(sig_o), 32'(exp_sig));
        check({tag, "_vec_end"}, 32'(vec_o), 32'd31);
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        cyc       = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        rec_ready = 1'b1;
        resp_mode = 0;
        #1;
        check("rst_outs", outs(), 32'd0);
        repeat (3) @(posedge CK);
        #1;
        reset = 1'b0;

        // 1: idle after reset, no start.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("s1_idle_outs", outs(), 32'd0);
        end

        // 2: plain sweep, responses tied low.
        start_sweep();
        check("s2_busy", 32'(busy_o), 32'd1);
        check("s2_first_vec", 32'(vec_o), 32'd0);
        full_sweep("s2", 64, 16'h0000);
        tick();
        check("s2_done_pulse_end", 32'(done_o), 32'd0);
        check("s2_done_count", 32'(done_cnt), 32'd1);
        check("s2_idle", 32'(busy_o), 32'd0);

        // 3: response high only on the last vector.
        resp_mode = 1;
        start_sweep();
        full_sweep("s3", 64, 16'h0001);
        check("s3_rec_resp", 32'(rec_resp), 32'd1);
        check("s3_resp_sum", 32'(resp_sum()), 32'd1);

        // Start on the done cycle is honoured at the next edge.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("b2b_state", {busy_o, 10'(vec_o), 16'(sig_o)}, {1'b1, 10'd0, 16'h0000});
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("b2b_abort_idle", 32'(busy_o), 32'd0);
        resp_mode = 0;

        // Start and abort together in IDLE: abort wins.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_abort_idle", 32'(busy_o), 32'd0);

        // 4: back-pressure at vector 7.
        start_sweep();
        wait_rec("s4", 7);
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s4_stall_hold", {rec_valid, rec_vec, vec_o}, {1'b1, 5'd7, 5'd7});
        end
        rec_ready = 1'b1;
        full_sweep("s4", 69, 16'h0000);

        // 5: abort in HOLD at vector 10, responses = vector LSB.
        resp_mode = 2;
        start_sweep();
        wait_rec("s5", 10);
        abort_i   = 1'b1;
        rec_ready = 1'b0;
        tick();
        abort_i   = 1'b0;
        rec_ready = 1'b1;
        check("s5_abort_state", {busy_o, rec_valid, vec_o}, {1'b0, 1'b0, 5'd10});
        check("s5_partial_sig", 32'(sig_o), 32'h0000_02AA);
        check("s5_rec_count", 32'(rec_vec_q.size()), 32'd10);
        repeat (4) tick();
        check("s5_no_done", 32'(done_cnt), 32'd0);
        check("s5_stays_idle", {busy_o, vec_o}, {1'b0, 5'd10});
        resp_mode = 0;
        start_sweep();
        check("s5_restart", {vec_o, sig_o}, {5'd0, 16'h0000});
        full_sweep("s5r", 64, 16'h0000);

        // 6: start while busy is ignored, then reset mid-sweep.
        start_sweep();
        wait_vec("s6a", 3);
        start_i = 1'b1;
        repeat (4) tick();
        start_i = 1'b0;
        check("s6_start_ignored", {busy_o, vec_o}, {1'b1, 5'd5});
        wait_vec("s6b", 16);
        #2;
        reset = 1'b1;
        #1;
        check("s6_async_rst", outs(), 32'd0);
        check("s6_recs_pre_rst", 32'(rec_vec_q.size()), 32'd16);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s6_post_rst_idle", outs(), 32'd0);
        end
        check("s6_no_new_rec", 32'(rec_vec_q.size()), 32'd16);
        start_sweep();
        full_sweep("s6", 64, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
